// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Optional sync feature (top level) is enabled by defining CLK_DIVIDER_SYNC_EN.
package clk_div_pkg;
    localparam int DIV_MIN         = 2;
    localparam int DEFAULT_DIV_VAL = 250;
    localparam int DIV_W_DEF       = 16;

    typedef logic [DIV_W_DEF-1:0] div_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/shadow divisor with pending flag,
// registered clk_out and tick. Divisor changes only take effect at a wrap or sync.
module clk_div_channel #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 250
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_wr_div,
    output logic             o_pending,
    output logic             o_clk_out,
    output logic             o_tick
);
    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] r_cnt, r_div, r_shd;
    logic             r_pnd, r_clk, r_tick;
    logic [CNT_W-1:0] w_cnt_nxt, w_div_nxt, w_shd_nxt;
    logic             w_pnd_nxt, w_wrap, w_apply;

    assign w_wrap  = i_en && (r_cnt == r_div - 1'b1);
    assign w_apply = i_en && (w_wrap || i_sync);

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_div_nxt = r_div;
        w_shd_nxt = r_shd;
        w_pnd_nxt = r_pnd;
        if (!i_en || w_apply) w_cnt_nxt = '0;
        else                  w_cnt_nxt = r_cnt + 1'b1;
        // A stopped channel has no period in flight, so the shadow loads immediately.
        if ((w_apply || !i_en) && r_pnd) begin
            w_div_nxt = r_shd;
            w_pnd_nxt = 1'b0;
        end
        if (i_wr) begin
            w_shd_nxt = i_wr_div;
            if (w_apply) begin
                w_div_nxt = i_wr_div;
                w_pnd_nxt = 1'b0;
            end else begin
                w_pnd_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_div  <= RST_DIV;
            r_shd  <= RST_DIV;
            r_pnd  <= 1'b0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_div  <= w_div_nxt;
            r_shd  <= w_shd_nxt;
            r_pnd  <= w_pnd_nxt;
            // clk_out tracks the count it will sit beside, keeping it aligned with the register.
            r_clk  <= i_en && (w_cnt_nxt < (w_div_nxt >> 1));
            r_tick <= w_wrap && !i_sync;
        end
    end

    assign o_pending = r_pnd;
    assign o_clk_out = r_clk;
    assign o_tick    = r_tick;
endmodule

// File: rtl/clock_divider_multi.sv
// NUM_CH independent programmable clock dividers with write decode and ack.
// Define CLK_DIVIDER_SYNC_EN to add sync_in, which phase-aligns all enabled channels.
module clock_divider_multi
    import clk_div_pkg::*;
#(
    parameter  int NUM_CH      = 2,
    parameter  int CNT_W       = 16,
    parameter  int DEFAULT_DIV = DEFAULT_DIV_VAL,
    localparam int CH_W        = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
`ifdef CLK_DIVIDER_SYNC_EN
    input  logic              sync_in,
`endif
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    output logic              wr_ack,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);
    logic              r_ack;
    logic              w_valid, w_sync;
    logic [CNT_W-1:0]  w_div_cl;
    logic [NUM_CH-1:0] w_wr;

`ifdef CLK_DIVIDER_SYNC_EN
    assign w_sync = sync_in;
`else
    assign w_sync = 1'b0;
`endif

    assign w_valid  = wr_en && (int'(wr_ch) < NUM_CH);
    assign w_div_cl = (wr_div < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : wr_div;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_ack <= 1'b0;
        else        r_ack <= w_valid;
    end
    assign wr_ack = r_ack;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_wr[g] = w_valid && (wr_ch == CH_W'(g));
        clk_div_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .i_en      (ch_en[g]),
            .i_sync    (w_sync),
            .i_wr      (w_wr[g]),
            .i_wr_div  (w_div_cl),
            .o_pending (pending[g]),
            .o_clk_out (clk_out[g]),
            .o_tick    (tick[g])
        );
    end
endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi (3 channels so an out-of-range channel is encodable).
module tb_clock_divider_multi;
    localparam int NCH = 3;
    localparam int CW  = 16;
    localparam int CHW = 2;

    typedef struct {
        int ch;
        int div;
        int per;
        int hi;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [NCH-1:0] ch_en;
    logic           wr_en;
    logic [CHW-1:0] wr_ch;
    logic [CW-1:0]  wr_div;
    logic           wr_ack;
    logic [NCH-1:0] pending, clk_out, tick;
`ifdef CLK_DIVIDER_SYNC_EN
    logic           sync_in = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #10 clk = ~clk;

    clock_divider_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(250)) dut (
        .clk     (clk),
        .reset   (reset),
`ifdef CLK_DIVIDER_SYNC_EN
        .sync_in (sync_in),
`endif
        .ch_en   (ch_en),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .wr_ack  (wr_ack),
        .pending (pending),
        .clk_out (clk_out),
        .tick    (tick)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wr(input int ch, input int div);
        wr_en  = 1'b1;
        wr_ch  = CHW'(ch);
        wr_div = CW'(div);
        step();
        wr_en  = 1'b0;
    endtask

    // Steps until a fresh tick on channel c; returns cycles taken.
    task automatic wait_tick(input int c, input string name, output int n);
        n = 0;
        repeat (1000) begin
            step();
            n++;
            if (tick[c]) break;
        end
        if (!tick[c]) chk({name, "_timeout"}, int'(tick[c]), 1);
    endtask

    // Called on a tick sample; measures cycles to the next tick and clk_out high time.
    task automatic measure(input int c, input string name, input int per, input int hi);
        int n, h;
        n = 0;
        h = int'(clk_out[c]);
        repeat (1000) begin
            step();
            n++;
            if (tick[c]) break;
            h += int'(clk_out[c]);
        end
        chk({name, "_period"}, n, per);
        chk({name, "_high"}, h, hi);
    endtask

    initial begin
        vec_t tbl[6];
        int   n, bad, t8, t24;
        tbl[0] = '{ch: 0, div: 0,  per: 2,  hi: 1};
        tbl[1] = '{ch: 0, div: 1,  per: 2,  hi: 1};
        tbl[2] = '{ch: 0, div: 3,  per: 3,  hi: 1};
        tbl[3] = '{ch: 1, div: 7,  per: 7,  hi: 3};
        tbl[4] = '{ch: 1, div: 2,  per: 2,  hi: 1};
        tbl[5] = '{ch: 2, div: 16, per: 16, hi: 8};

        ch_en = '1; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
        repeat (3) step();
        chk("rst_ack",     int'(wr_ack),  0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_clk_out", int'(clk_out), 0);
        chk("rst_tick",    int'(tick),    0);

        // Default divisor after release
        reset = 1'b1;
        wait_tick(0, "first", n);
        chk("first_tick_latency", n, 250);
        measure(0, "dflt", 250, 125);
        chk("dflt_pending", int'(pending), 0);

        // Write mid-period: old period completes, then the new one
        repeat (100) step();
        do_wr(0, 10);
        chk("mid_ack", int'(wr_ack), 1);
        chk("mid_pending", int'(pending[0]), 1);
        step();
        chk("mid_ack_one_cycle", int'(wr_ack), 0);
        wait_tick(0, "mid", n);
        chk("mid_old_period", n + 102, 250);
        chk("mid_pending_clear", int'(pending[0]), 0);
        measure(0, "mid_new", 10, 5);

        for (int i = 0; i < 6; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            do_wr(tbl[i].ch, tbl[i].div);
            chk({nm, "_ack"}, int'(wr_ack), 1);
            wait_tick(tbl[i].ch, nm, n);
            measure(tbl[i].ch, nm, tbl[i].per, tbl[i].hi);
            chk({nm, "_pending"}, int'(pending[tbl[i].ch]), 0);
        end

        // Collision on ch1 (div 2): write lands on the wrap edge
        wait_tick(1, "coll_sync", n);
        step();
        do_wr(1, 20);
        chk("coll_ack", int'(wr_ack), 1);
        chk("coll_tick", int'(tick[1]), 1);
        chk("coll_pending", int'(pending[1]), 0);
        measure(1, "coll", 20, 10);
        chk("coll_pending_after", int'(pending[1]), 0);

        // Disable ch0 for 37 cycles, program it while stopped
        ch_en[0] = 1'b0;
        bad = 0;
        repeat (5) begin step(); bad += int'(clk_out[0] | tick[0]); end
        do_wr(0, 9);
        bad += int'(clk_out[0] | tick[0]);
        chk("dis_ack", int'(wr_ack), 1);
        chk("dis_pending_set", int'(pending[0]), 1);
        step();
        bad += int'(clk_out[0] | tick[0]);
        chk("dis_pending_applied", int'(pending[0]), 0);
        repeat (30) begin step(); bad += int'(clk_out[0] | tick[0]); end
        chk("dis_quiet", bad, 0);
        ch_en[0] = 1'b1;
        wait_tick(0, "reen", n);
        chk("reen_first_tick", n, 9);
        measure(0, "reen", 9, 4);

        // Out-of-range channel is ignored
        do_wr(NCH, 5);
        chk("inv_ack", int'(wr_ack), 0);
        chk("inv_pending", int'(pending), 0);
        wait_tick(2, "inv", n);
        measure(2, "inv_ch2", 16, 8);

        // Back-to-back writes: last one wins
        wr_en = 1'b1; wr_ch = 2'd2; wr_div = 16'd5;
        step();
        chk("b2b_ack0", int'(wr_ack), 1);
        wr_div = 16'd6;
        step();
        chk("b2b_ack1", int'(wr_ack), 1);
        wr_en = 1'b0;
        wait_tick(2, "b2b", n);
        measure(2, "b2b", 6, 3);

`ifdef CLK_DIVIDER_SYNC_EN
        do_wr(0, 8);
        do_wr(1, 12);
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        chk("sync_pending", int'(pending[1:0]), 0);
        chk("sync_tick_suppressed", int'(tick[1:0]), 0);
        chk("sync_clk_out", int'(clk_out[1:0]), 3);
        t8 = 0; t24 = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (tick[0] && t8 == 0) t8 = k;
            if (tick[0] && tick[1] && t24 == 0) t24 = k;
        end
        chk("sync_ch0_first", t8, 8);
        chk("sync_coincide", t24, 24);
`endif

        // Reset mid-period discards programmed divisors
        do_wr(1, 40);
        chk("rstm_pending_set", int'(pending[1]), 1);
        reset = 1'b0;
        #1;
        chk("rstm_pending", int'(pending), 0);
        chk("rstm_clk_out", int'(clk_out), 0);
        step();
        reset = 1'b1;
        wait_tick(1, "rstm", n);
        chk("rstm_first_tick", n, 250);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
